// File: rtl/otter_mem_if.sv
// otter_mem_if: serialises OTTER fetch/load/store requests onto a single req/ack memory bus
// with lane steering, load extension and a timeout watchdog. Define OTTER_MMIO_EN for the MMIO bypass.
module otter_mem_if #(
    parameter int unsigned TIMEOUT_CYC = 255
`ifdef OTTER_MMIO_EN
    ,
    parameter logic [31:0] IO_BASE     = 32'h1100_0000
`endif
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        rden1,
    input  logic [31:0] addr1,
    input  logic        rden2,
    input  logic        we2,
    input  logic [31:0] addr2,
    input  logic [1:0]  size2,
    input  logic        sign2,
    input  logic [31:0] din2,
    output logic [31:0] ir,
    output logic [31:0] dout2,
    output logic        done1,
    output logic        done2,
    output logic        err2,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
`ifdef OTTER_MMIO_EN
    ,
    input  logic [31:0] io_in,
    output logic [31:0] io_out,
    output logic [31:0] io_addr,
    output logic        io_wr
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_RESP} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_is_fetch;
    logic        r_is_store;
    logic        r_err;
    logic        r_sign;
    logic [1:0]  r_lo;
    logic [1:0]  r_size;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [29:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_ir;
    logic [31:0] r_dout;

    logic        w_data;
    logic        w_word;
    logic        w_half;
    logic        w_misal;
    logic        w_io;
    logic        w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic        w_unused;

    // Fetches are word aligned by contract, so the low address bits carry no information.
    assign w_unused = &{1'b0, addr1[1:0]};

    assign w_data  = we2 | rden2;
    assign w_word  = size2[1];
    assign w_half  = (size2 == 2'b01);
    assign w_misal = w_word ? (addr2[1:0] != 2'b00) : (w_half & addr2[0]);

`ifdef OTTER_MMIO_EN
    assign w_io = (addr2 >= IO_BASE);
`else
    assign w_io = 1'b0;
`endif

    assign w_tmo = (TIMEOUT_CYC != 0) && (r_cnt == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = din2;
        if (w_half) begin
            w_be    = 4'b0011 << addr2[1:0];
            w_wdata = {2{din2[15:0]}};
        end else if (!w_word) begin
            w_be    = 4'b0001 << addr2[1:0];
            w_wdata = {4{din2[7:0]}};
        end
    end

    // Shifting by the byte offset brings the addressed lane down to bit 0 for both byte and half.
    assign w_shift = bus_rdata >> {r_lo, 3'b000};

    always_comb begin
        w_load = bus_rdata;
        if (r_size == 2'b00) begin
            w_load = r_sign ? {{24{w_shift[7]}}, w_shift[7:0]} : {24'b0, w_shift[7:0]};
        end else if (r_size == 2'b01) begin
            w_load = r_sign ? {{16{w_shift[15]}}, w_shift[15:0]} : {16'b0, w_shift[15:0]};
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_data) begin
                    w_state_nxt = (w_io || w_misal) ? S_RESP : S_DATA;
                end else if (rden1) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH, S_DATA: begin
                if (bus_ack || w_tmo) begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != S_IDLE);
        done1 = (r_state == S_RESP) &&  r_is_fetch;
        done2 = (r_state == S_RESP) && !r_is_fetch;
        err2  = (r_state == S_RESP) &&  r_err;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_is_fetch <= 1'b0;
            r_is_store <= 1'b0;
            r_err      <= 1'b0;
            r_sign     <= 1'b0;
            r_lo       <= '0;
            r_size     <= '0;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_ir       <= '0;
            r_dout     <= '0;
`ifdef OTTER_MMIO_EN
            io_out     <= '0;
            io_addr    <= '0;
            io_wr      <= 1'b0;
`endif
        end else begin
`ifdef OTTER_MMIO_EN
            io_wr <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_data) begin
                        r_is_fetch <= 1'b0;
                        r_is_store <= we2;
                        r_lo       <= addr2[1:0];
                        r_size     <= size2;
                        r_sign     <= sign2;
                        r_err      <= w_misal & ~w_io;
                        if (w_io) begin
`ifdef OTTER_MMIO_EN
                            io_addr <= addr2;
                            if (we2) begin
                                io_out <= din2;
                                io_wr  <= 1'b1;
                            end else begin
                                r_dout <= io_in;
                            end
`endif
                        end else if (!w_misal) begin
                            r_req   <= 1'b1;
                            r_we    <= we2;
                            r_addr  <= addr2[31:2];
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                        end
                    end else if (rden1) begin
                        r_is_fetch <= 1'b1;
                        r_err      <= 1'b0;
                        r_req      <= 1'b1;
                        r_we       <= 1'b0;
                        r_addr     <= addr1[31:2];
                        r_be       <= 4'b1111;
                    end
                end
                S_FETCH, S_DATA: begin
                    if (bus_ack) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        r_be  <= '0;
                        if (r_is_fetch) begin
                            r_ir <= bus_rdata;
                        end else if (!r_is_store) begin
                            r_dout <= w_load;
                        end
                    end else if (w_tmo) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        r_be  <= '0;
                        r_err <= 1'b1;
                        if (r_is_fetch) begin
                            r_ir <= NOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign ir        = r_ir;
    assign dout2     = r_dout;
    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_otter_mem_if.sv
// Randomised self-checking bench for otter_mem_if: bench-side bus responder plus a transaction-level
// reference model; MMIO bypass cases are exercised when OTTER_MMIO_EN is defined.
module tb_otter_mem_if;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        RST;
    logic        rden1;
    logic [31:0] addr1;
    logic        rden2;
    logic        we2;
    logic [31:0] addr2;
    logic [1:0]  size2;
    logic        sign2;
    logic [31:0] din2;
    logic [31:0] ir;
    logic [31:0] dout2;
    logic        done1;
    logic        done2;
    logic        err2;
    logic        busy;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
`ifdef OTTER_MMIO_EN
    logic [31:0] io_in;
    logic [31:0] io_out;
    logic [31:0] io_addr;
    logic        io_wr;
`endif

    otter_mem_if #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .RST(RST),
        .rden1(rden1), .addr1(addr1),
        .rden2(rden2), .we2(we2), .addr2(addr2), .size2(size2), .sign2(sign2), .din2(din2),
        .ir(ir), .dout2(dout2), .done1(done1), .done2(done2), .err2(err2), .busy(busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
`ifdef OTTER_MMIO_EN
        , .io_in(io_in), .io_out(io_out), .io_addr(io_addr), .io_wr(io_wr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int dones    = 0;

    // Expectations for the transaction in flight, produced by the model in run_txn.
    logic        chk_en;
    logic        e_bus;
    logic        e_fetch;
    logic        e_err;
    logic        e_we;
    logic [29:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_ir;
    logic [31:0] e_dout;
    logic [31:0] m_ir;
    logic [31:0] m_dout;

    logic [29:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic        obs_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] rd, input logic [1:0] lo,
                                             input logic [1:0] sz, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*lo +: 8];
        h = rd[8*lo[1] * 2 +: 16];
        if (sz[1]) return rd;
        if (sz == 2'b01) return sg ? {{16{h[15]}}, h} : {16'h0, h};
        return sg ? {{24{b[7]}}, b} : {24'h0, b};
    endfunction

    task automatic reset_zero(input string tag);
        chk({tag, "_ir"},     ir, 32'h0);
        chk({tag, "_dout2"},  dout2, 32'h0);
        chk({tag, "_flags"},  {26'h0, done1, done2, err2, busy, bus_req, bus_we}, 32'h0);
        chk({tag, "_baddr"},  {2'b0, bus_addr}, 32'h0);
        chk({tag, "_be"},     {28'h0, bus_be}, 32'h0);
        chk({tag, "_wdata"},  bus_wdata, 32'h0);
    endtask

    // Per-cycle compare against the current expectation record.
    always @(negedge clk) begin
        if (chk_en && !RST) begin
            chk("done_excl", {31'h0, done1 & done2}, 32'h0);
            if (!e_bus) chk("no_bus_req", {31'h0, bus_req}, 32'h0);
            if (bus_req) begin
                chk("bus_addr", {2'b0, bus_addr}, {2'b0, e_addr});
                chk("bus_be", {28'h0, bus_be}, {28'h0, e_be});
                chk("bus_we", {31'h0, bus_we}, {31'h0, e_we});
                if (e_we) chk("bus_wdata", bus_wdata, e_wdata);
            end
            if (done1 || done2) begin
                dones++;
                chk("done_kind", {31'h0, done1}, {31'h0, e_fetch});
                chk("err2", {31'h0, err2}, {31'h0, e_err});
                chk("busy_resp", {31'h0, busy}, 32'h1);
                chk("ir", ir, e_ir);
                chk("dout2", dout2, e_dout);
            end else begin
                chk("err2_quiet", {31'h0, err2}, 32'h0);
            end
        end
    end

    task automatic run_txn(input logic f1, input logic r2, input logic w2,
                           input logic [31:0] a1, input logic [31:0] a2, input logic [1:0] sz,
                           input logic sg, input logic [31:0] din, input int lat,
                           input logic [31:0] rd);
        logic       misal;
        logic       tmo;
        logic [1:0] lo;
        int         d0;
        int         reqc;
        int         want_reqc;
        logic       got;
        lo  = a2[1:0];
        tmo = (lat >= int'(TMO));
        if (r2 || w2) begin
            if (sz[1])            misal = (lo != 2'b00);
            else if (sz == 2'b01) misal = lo[0];
            else                  misal = 1'b0;
            e_fetch = 1'b0;
            e_we    = w2;
            e_addr  = a2[31:2];
            if (sz[1]) begin
                e_be = 4'hF; e_wdata = din;
            end else if (sz == 2'b01) begin
                e_be = (lo == 2'd0) ? 4'h3 : 4'hC; e_wdata = {din[15:0], din[15:0]};
            end else begin
                e_be = 4'(1 << lo); e_wdata = {din[7:0], din[7:0], din[7:0], din[7:0]};
            end
            e_bus  = !misal;
            e_err  = misal || tmo;
            e_ir   = m_ir;
            e_dout = (!w2 && !misal && !tmo) ? ld_model(rd, lo, sz, sg) : m_dout;
        end else begin
            misal   = 1'b0;
            e_fetch = 1'b1;
            e_we    = 1'b0;
            e_addr  = a1[31:2];
            e_be    = 4'hF;
            e_wdata = 32'h0;
            e_bus   = 1'b1;
            e_err   = tmo;
            e_ir    = tmo ? 32'h0000_0013 : rd;
            e_dout  = m_dout;
        end
        want_reqc = !e_bus ? 0 : (tmo ? int'(TMO) : lat + 1);
        rden1 = f1; rden2 = r2; we2 = w2; addr1 = a1; addr2 = a2;
        size2 = sz; sign2 = sg; din2 = din;
        d0 = dones; reqc = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (done1 || done2) begin
                got = 1'b1;
            end else if (bus_req) begin
                reqc++;
                obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata; obs_we = bus_we;
                if (reqc == lat + 1) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd;
                end
            end
        end
        chk("done_seen", {31'h0, got}, 32'h1);
        rden1 = 1'b0; rden2 = 1'b0; we2 = 1'b0;
        m_ir = e_ir; m_dout = e_dout;
        @(posedge clk); #1;
        e_bus = 1'b0;
        if (tmo) begin
            bus_ack = 1'b1;
            @(posedge clk); #1;
            bus_ack = 1'b0;
            @(posedge clk); #1;
        end
        chk("req_cycles", reqc, want_reqc);
        chk("done_count", dones, d0 + 1);
        chk("busy_idle", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        logic [31:0] ra2;
        logic [1:0]  rsz;
        int          t;
        int          rlat;
        RST = 1'b1; rden1 = 1'b0; rden2 = 1'b0; we2 = 1'b0;
        addr1 = '0; addr2 = '0; size2 = '0; sign2 = 1'b0; din2 = '0;
        bus_rdata = '0; bus_ack = 1'b0;
`ifdef OTTER_MMIO_EN
        io_in = '0;
`endif
        chk_en = 1'b0; e_bus = 1'b0; e_fetch = 1'b0; e_err = 1'b0; e_we = 1'b0;
        e_addr = '0; e_be = '0; e_wdata = '0; e_ir = '0; e_dout = '0;
        m_ir = '0; m_dout = '0;
        obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 1'b0;

        #12;
        reset_zero("reset");
        @(negedge clk); RST = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Fetch, ack 2 cycles after bus_req.
        run_txn(1, 0, 0, 32'h0000_0004, 32'h0, 2'b10, 0, 32'h0, 2, 32'h0050_0093);
        chk("fetch_addr", {2'b0, obs_addr}, 32'h1);
        chk("fetch_be", {28'h0, obs_be}, 32'hF);
        chk("fetch_ir", ir, 32'h0050_0093);

        // Signed byte load from the top lane.
        run_txn(0, 1, 0, 32'h0, 32'h0000_1003, 2'b00, 1, 32'h0, 0, 32'h80FF_FFFF);
        chk("lb_be", {28'h0, obs_be}, 32'h8);
        chk("lb_dout", dout2, 32'hFFFF_FF80);

        // Half store to the upper half.
        run_txn(0, 0, 1, 32'h0, 32'h0000_2002, 2'b01, 0, 32'h1234_ABCD, 1, 32'h0);
        chk("sh_be", {28'h0, obs_be}, 32'hC);
        chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'h0, obs_we}, 32'h1);
        chk("sh_dout", dout2, 32'hFFFF_FF80);

        // Misaligned word load: error, no bus cycle.
        run_txn(0, 1, 0, 32'h0, 32'h0000_0006, 2'b10, 0, 32'h0, 0, 32'h0);
        chk("mis_dout", dout2, 32'hFFFF_FF80);

        // Fetch timeout, then a late ack in IDLE.
        run_txn(1, 0, 0, 32'h0000_0008, 32'h0, 2'b10, 0, 32'h0, 100, 32'hDEAD_BEEF);
        chk("tmo_ir", ir, 32'h0000_0013);

        // Ack arriving on the last permitted waiting cycle still completes.
        run_txn(0, 1, 0, 32'h0, 32'h0000_0100, 2'b10, 0, 32'h0, int'(TMO) - 1, 32'h1357_9BDF);
        chk("edge_dout", dout2, 32'h1357_9BDF);

        // Store and fetch requested together: the store wins, then reset mid-DATA.
        chk_en = 1'b0;
        rden1 = 1'b1; we2 = 1'b1; addr1 = 32'h40; addr2 = 32'h0000_3000;
        size2 = 2'b10; din2 = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("prio_we", {31'h0, bus_we}, 32'h1);
        chk("prio_addr", {2'b0, bus_addr}, 32'h0000_0C00);
        @(posedge clk); #2;
        RST = 1'b1;
        #1;
        reset_zero("rst_mid");
        @(negedge clk);
        rden1 = 1'b0; we2 = 1'b0;
        @(negedge clk);
        RST = 1'b0; bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("late_ack_quiet", {29'h0, done1, done2, bus_req}, 32'h0);
        @(posedge clk); #1;
        reset_zero("post_rst");
        m_ir = '0; m_dout = '0; e_bus = 1'b0;
        chk_en = 1'b1;

        for (int n = 0; n < 200; n++) begin
            t   = $urandom_range(0, 2);
            rsz = 2'($urandom);
            ra2 = $urandom & 32'h0FFF_FFFF;
            if ($urandom_range(0, 3) != 0) begin
                if (rsz[1]) ra2[1:0] = 2'b00;
                else if (rsz == 2'b01) ra2[0] = 1'b0;
            end
            rlat = ($urandom_range(0, 7) == 0) ? int'(TMO) + 3 : $urandom_range(0, TMO - 1);
            if (t == 0)
                run_txn(1, 0, 0, $urandom & 32'h0FFF_FFFC, ra2, rsz, 1'($urandom), $urandom, rlat, $urandom);
            else if (t == 1)
                run_txn(1'($urandom), 1, 1'($urandom_range(0, 3) == 0), $urandom & 32'h0FFF_FFFC, ra2, rsz,
                        1'($urandom), $urandom, rlat, $urandom);
            else
                run_txn(1'($urandom), 0, 1, $urandom & 32'h0FFF_FFFC, ra2, rsz, 1'($urandom), $urandom, rlat, $urandom);
        end

`ifdef OTTER_MMIO_EN
        e_bus = 1'b0; e_fetch = 1'b0; e_err = 1'b0; e_ir = m_ir; e_dout = m_dout;
        we2 = 1'b1; addr2 = 32'h1100_0000; din2 = 32'h5A5A_1234; size2 = 2'b00;
        @(posedge clk); #1;
        chk("io_wr", {31'h0, io_wr}, 32'h1);
        chk("io_out", io_out, 32'h5A5A_1234);
        chk("io_addr", io_addr, 32'h1100_0000);
        chk("io_done2", {31'h0, done2}, 32'h1);
        we2 = 1'b0;
        @(posedge clk); #1;
        chk("io_wr_pulse", {31'h0, io_wr}, 32'h0);
        io_in = 32'h8765_4321; e_dout = 32'h8765_4321;
        rden2 = 1'b1; addr2 = 32'h1100_0003; size2 = 2'b10;
        @(posedge clk); #1;
        chk("io_ld_dout", dout2, 32'h8765_4321);
        chk("io_ld_nowr", {31'h0, io_wr}, 32'h0);
        rden2 = 1'b0; m_dout = e_dout;
        @(posedge clk); #1;
        chk("io_ld_idle", {31'h0, busy}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
